spi_w25q_read32: RTL and testbench

- SPI mode-0 controller that reads one 32-bit word from a Winbond W25Qxxx serial NOR flash.
- On a start pulse it asserts chip select and sends the Read Data opcode (0x03) plus a 24-bit address, MSB first.
- It then shifts in 32 data bits and presents them on mem_data when busy drops.
- It sits between fabric logic (e.g. a boot loader or ROM fetcher) and the flash pins.

---
 rtl/spi_w25q_pkg.sv | 34 +++
 rtl/spi_w25q_read32_sck_timer.sv | 41 ++++
 rtl/spi_w25q_read32.sv | 125 ++++++++++++
 tb/tb_spi_w25q_read32.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_w25q_pkg.sv
// Shared constants and state type for the W25Q 32-bit read controller.
// Build option: define FAST_READ_EN to use the Fast Read opcode (0x0B)
// with 8 dummy bits between the address and the data phase.
package spi_w25q_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int DUMMY_BITS = 8;

  // Opcode plus address always fills one 32-bit outgoing shift word
  localparam int CMD_BITS = 8 + ADDR_BITS;

`ifdef FAST_READ_EN
  localparam logic [7:0] OP_CODE = OP_FAST_READ;
  localparam int PAD_BITS = DUMMY_BITS;
`else
  localparam logic [7:0] OP_CODE = OP_READ;
  localparam int PAD_BITS = 0;
`endif

  // Index of the first SCK bit carrying read data, and bits per transfer
  localparam int DATA_START = CMD_BITS + PAD_BITS;
  localparam int TOTAL_BITS = DATA_START + DATA_BITS;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

endpackage

// File: rtl/spi_w25q_read32_sck_timer.sv
// SCK half-period timer: while run_i is high it produces a mode-0 SCK
// (low phase first) with CLK_DIV clk cycles per half period, plus strobes
// marking the clk edges where phases change.
module spi_sck_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic phase_start_low_o,
  output logic phase_end_high_o,
  output logic spi_sck_o
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       sck_q;
  logic       half_done;

  assign half_done        = run_i && (cnt_q == HALF_LAST);
  assign phase_end_high_o = half_done && sck_q;
  // SCK runs continuously, so the next low phase begins on the very edge
  // that closes the current high phase.
  assign phase_start_low_o = half_done && sck_q;
  assign spi_sck_o         = sck_q;

  // Half-period counter; SCK toggles each time a half period completes
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (half_done) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_w25q_read32.sv
// SPI mode-0 controller reading one 32-bit word from a W25Qxxx NOR flash.
// Sends opcode + 24-bit address MSB first, then shifts in 32 data bits.
// Build option: FAST_READ_EN selects Fast Read (0x0B) with 8 dummy bits.
module spi_w25q_read32
  import spi_w25q_pkg::*;
#(
  parameter int CLK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] mem_addr_i,
  output logic [DATA_BITS-1:0] mem_data_o,
  output logic                 busy_o,
  output logic                 spi_sck_o,
  output logic                 spi_cs_n_o,
  output logic                 spi_copi_o,
  input  logic                 spi_cipo_i
);

  localparam logic [6:0]  LAST_BIT       = 7'(TOTAL_BITS - 1);
  localparam logic [6:0]  FIRST_DATA_BIT = 7'(DATA_START);
  localparam logic [15:0] DONE_LAST      = 16'(CS_HIGH_CYCLES - 1);

  state_e                state_q;
  logic [CMD_BITS-1:0]   shift_out_q;
  logic [DATA_BITS-1:0]  shift_in_q;
  logic [DATA_BITS-1:0]  shift_in_d;
  logic [DATA_BITS-1:0]  mem_data_q;
  logic [6:0]            bit_cnt_q;
  logic [15:0]           done_cnt_q;
  logic                  busy_q;
  logic                  cs_n_q;
  logic                  copi_q;

  logic                  sck_run;
  logic                  phase_start_low;
  logic                  phase_end_high;
  logic                  sck_level;

  assign sck_run = (state_q == XFER);

  spi_sck_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_timer (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .run_i            (sck_run),
    .phase_start_low_o(phase_start_low),
    .phase_end_high_o (phase_end_high),
    .spi_sck_o        (sck_level)
  );

  // Receive shifter next value: newest CIPO bit enters at the LSB
  always_comb begin
    shift_in_d = {shift_in_q[DATA_BITS-2:0], spi_cipo_i};
  end

  // Transfer sequencer: command/address shift-out, data shift-in, CS recovery
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      copi_q      <= 1'b0;
      mem_data_q  <= '0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      bit_cnt_q   <= '0;
      done_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_out_q <= {OP_CODE, mem_addr_i};
            copi_q      <= OP_CODE[7];
            shift_in_q  <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b1;
            cs_n_q      <= 1'b0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          // Zeros fill in behind the command word, so dummy and data-phase
          // bits drive COPI low without any extra selection.
          if (phase_start_low) begin
            shift_out_q <= {shift_out_q[CMD_BITS-2:0], 1'b0};
            copi_q      <= shift_out_q[CMD_BITS-2];
          end
          if (phase_end_high) begin
            if (bit_cnt_q >= FIRST_DATA_BIT) begin
              shift_in_q <= shift_in_d;
            end
            if (bit_cnt_q == LAST_BIT) begin
              cs_n_q     <= 1'b1;
              done_cnt_q <= '0;
              state_q    <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
          end
        end
        DONE: begin
          if (done_cnt_q == DONE_LAST) begin
            mem_data_q <= shift_in_q;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            done_cnt_q <= done_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_data_o = mem_data_q;
  assign busy_o     = busy_q;
  assign spi_sck_o  = sck_level;
  assign spi_cs_n_o = cs_n_q;
  assign spi_copi_o = copi_q;

endmodule

// File: tb/tb_spi_w25q_read32.sv
// Directed bench for spi_w25q_read32: two instances (CLK_DIV=1 and 3),
// each with a behavioural W25Q flash model and an SPI bus monitor.
module tb_spi_w25q_read32;

`ifdef FAST_READ_EN
  localparam logic [7:0] TB_OP     = 8'h0B;
  localparam int         TB_BITS   = 72;
  localparam int         TB_DSTART = 40;
`else
  localparam logic [7:0] TB_OP     = 8'h03;
  localparam int         TB_BITS   = 64;
  localparam int         TB_DSTART = 32;
`endif
  localparam int DIV_B = 3;
  localparam int CSH_A = 1;
  localparam int CSH_B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startA = 1'b0;
  logic        startB = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] dataA, dataB;
  logic        busyA, busyB, sckA, sckB, csA, csB, copiA, copiB;
  logic        cipoA = 1'bz;
  logic        cipoB = 1'bz;
  bit          allOnes = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  spi_w25q_read32 #(.CLK_DIV(1), .CS_HIGH_CYCLES(CSH_A)) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(startA), .mem_addr_i(addr),
    .mem_data_o(dataA), .busy_o(busyA), .spi_sck_o(sckA),
    .spi_cs_n_o(csA), .spi_copi_o(copiA), .spi_cipo_i(cipoA));

  spi_w25q_read32 #(.CLK_DIV(DIV_B), .CS_HIGH_CYCLES(CSH_B)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(startB), .mem_addr_i(addr),
    .mem_data_o(dataB), .busy_o(busyB), .spi_sck_o(sckB),
    .spi_cs_n_o(csB), .spi_copi_o(copiB), .spi_cipo_i(cipoB));

  // Flash contents as a function of the address the flash received
  function automatic logic [31:0] modelWord(input logic [23:0] a);
    if (allOnes) return 32'hFFFFFFFF;
    if (a == 24'h010000) return 32'hDEADBEEF;
    return {8'hA5, a} ^ 32'h00FF00FF;
  endfunction

  // ---------------- flash model and bus monitor, instance A ----------------
  int          riseA = 0, fallA = 0, csLowA = 0, csHighA = 0, busyCntA = 0;
  int          txnA = 0, stabErrA = 0, idleErrA = 0;
  logic [71:0] copiBitsA = '0;
  logic [31:0] wordA = '0, shA = '0;
  logic        prevSckA = 1'b0, prevCopiA = 1'b0;

  // New transaction: clear per-transfer bus records
  always @(negedge csA) begin
    riseA = 0; copiBitsA = '0; csLowA = 0; txnA++;
  end
  always @(posedge csA) csHighA = 0;
  always @(posedge busyA) busyCntA = 0;

  // Flash samples COPI on SCK rise and looks up the word once the address is in
  always @(posedge sckA) begin
    if (!csA) begin
      copiBitsA = {copiBitsA[70:0], copiA};
      riseA++;
      if (riseA == 32) wordA = modelWord(copiBitsA[23:0]);
    end
  end

  // Flash drives CIPO after SCK falls during the data phase, Z otherwise
  always @(negedge sckA or posedge csA) begin
    if (csA) begin
      fallA = 0; cipoA = 1'bz;
    end else begin
      fallA++;
      if (fallA == TB_DSTART) shA = wordA; else shA = {shA[30:0], 1'b0};
      cipoA = (fallA >= TB_DSTART && fallA < TB_DSTART + 32) ? shA[31] : 1'bz;
    end
  end

  // Cycle-level timing checks sampled away from the active edge
  always @(negedge clk) begin
    if (!csA) csLowA++; else csHighA++;
    if (busyA) busyCntA++;
    if (!prevSckA && sckA && copiA !== prevCopiA) stabErrA++;
    if (csA && sckA) idleErrA++;
    prevSckA = sckA; prevCopiA = copiA;
  end

  // ---------------- flash model and bus monitor, instance B ----------------
  int          riseB = 0, fallB = 0, csLowB = 0, busyCntB = 0;
  int          stabErrB = 0, idleErrB = 0;
  logic [71:0] copiBitsB = '0;
  logic [31:0] wordB = '0, shB = '0;
  logic        prevSckB = 1'b0, prevCopiB = 1'b0;

  // New transaction: clear per-transfer bus records
  always @(negedge csB) begin
    riseB = 0; copiBitsB = '0; csLowB = 0;
  end
  always @(posedge busyB) busyCntB = 0;

  // Flash samples COPI on SCK rise and looks up the word once the address is in
  always @(posedge sckB) begin
    if (!csB) begin
      copiBitsB = {copiBitsB[70:0], copiB};
      riseB++;
      if (riseB == 32) wordB = modelWord(copiBitsB[23:0]);
    end
  end

  // Flash drives CIPO after SCK falls during the data phase, Z otherwise
  always @(negedge sckB or posedge csB) begin
    if (csB) begin
      fallB = 0; cipoB = 1'bz;
    end else begin
      fallB++;
      if (fallB == TB_DSTART) shB = wordB; else shB = {shB[30:0], 1'b0};
      cipoB = (fallB >= TB_DSTART && fallB < TB_DSTART + 32) ? shB[31] : 1'bz;
    end
  end

  // Cycle-level timing checks sampled away from the active edge
  always @(negedge clk) begin
    if (!csB) csLowB++;
    if (busyB) busyCntB++;
    if (!prevSckB && sckB && copiB !== prevCopiB) stabErrB++;
    if (csB && sckB) idleErrB++;
    prevSckB = sckB; prevCopiB = copiB;
  end

  // ---------------- helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] a, input bit useB);
    @(negedge clk);
    addr = a;
    if (useB) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitIdleA();
    int n = 0;
    while (busyA && n < 2000) begin @(negedge clk); n++; end
    checkOutput("timeoutA", {31'd0, busyA}, 32'd0);
  endtask

  task automatic waitIdleB();
    int n = 0;
    while (busyB && n < 4000) begin @(negedge clk); n++; end
    checkOutput("timeoutB", {31'd0, busyB}, 32'd0);
  endtask

  function automatic logic [31:0] cmdOf(input logic [71:0] bits);
    return bits[TB_BITS-1 -: 32];
  endfunction

  function automatic logic [31:0] tailOf(input logic [71:0] bits);
    return 32'((bits & ((72'd1 << (TB_BITS - 32)) - 72'd1)) != 72'd0);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int txnBefore;

    $display("[TB] start, TB_BITS=%0d", TB_BITS);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_dataA", dataA, 32'h0);
    checkOutput("rst_busyA", {31'd0, busyA}, 32'd0);
    checkOutput("rst_csA",   {31'd0, csA},   32'd1);
    checkOutput("rst_sckA",  {31'd0, sckA},  32'd0);
    checkOutput("rst_copiA", {31'd0, copiA}, 32'd0);
    checkOutput("rst_csB",   {31'd0, csB},   32'd1);

    // Basic read at 0x010000
    applyStimulus(24'h010000, 1'b0);
    waitIdleA();
    checkOutput("basic_data",  dataA, 32'hDEADBEEF);
    checkOutput("basic_cmd",   cmdOf(copiBitsA), {TB_OP, 24'h010000});
    checkOutput("basic_tail",  tailOf(copiBitsA), 32'd0);
    checkOutput("basic_rises", 32'(riseA), 32'(TB_BITS));
    checkOutput("basic_csLow", 32'(csLowA), 32'(2 * TB_BITS));
    checkOutput("basic_busy",  32'(busyCntA), 32'(2 * TB_BITS + CSH_A));

    // All ones with CIPO floating outside the data phase
    allOnes = 1'b1;
    applyStimulus(24'h00ABCD, 1'b0);
    waitIdleA();
    checkOutput("ones_data", dataA, 32'hFFFFFFFF);
    allOnes = 1'b0;

    // Slow clock instance, CLK_DIV=3, CS_HIGH_CYCLES=2
    applyStimulus(24'h123456, 1'b1);
    waitIdleB();
    checkOutput("divB_data",  dataB, 32'hA5ED34A9);
    checkOutput("divB_cmd",   cmdOf(copiBitsB), {TB_OP, 24'h123456});
    checkOutput("divB_rises", 32'(riseB), 32'(TB_BITS));
    checkOutput("divB_csLow", 32'(csLowB), 32'(2 * TB_BITS * DIV_B));
    checkOutput("divB_busy",  32'(busyCntB), 32'(2 * TB_BITS * DIV_B + CSH_B));
    checkOutput("divB_stab",  32'(stabErrB), 32'd0);
    checkOutput("divB_idle",  32'(idleErrB), 32'd0);

    // Start pulse while busy must be ignored
    txnBefore = txnA;
    applyStimulus(24'h000040, 1'b0);
    repeat (30) @(negedge clk);
    applyStimulus(24'h0ABCDE, 1'b0);
    waitIdleA();
    checkOutput("ignore_data", dataA, 32'hA5FF00BF);
    checkOutput("ignore_cmd",  cmdOf(copiBitsA), {TB_OP, 24'h000040});
    repeat (20) @(negedge clk);
    checkOutput("ignore_busy", {31'd0, busyA}, 32'd0);
    checkOutput("ignore_txn",  32'(txnA - txnBefore), 32'd1);

    // Reset in the middle of the command phase
    applyStimulus(24'h000040, 1'b0);
    n = 0;
    while (riseA < 20 && n < 500) begin @(negedge clk); n++; end
    checkOutput("abort_bit", 32'(riseA), 32'd20);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_cs",   {31'd0, csA},   32'd1);
    checkOutput("abort_sck",  {31'd0, sckA},  32'd0);
    checkOutput("abort_busy", {31'd0, busyA}, 32'd0);
    checkOutput("abort_data", dataA, 32'h0);
    rst = 1'b0;
    applyStimulus(24'h010000, 1'b0);
    waitIdleA();
    checkOutput("after_abort_data", dataA, 32'hDEADBEEF);
    checkOutput("after_abort_rise", 32'(riseA), 32'(TB_BITS));

    // Back-to-back with start held high
    @(negedge clk);
    addr = 24'h000000;
    startA = 1'b1;
    @(negedge clk);
    addr = 24'hFFFFFC;
    waitIdleA();
    checkOutput("b2b_data0", dataA, 32'hA5FF00FF);
    checkOutput("b2b_cmd0",  cmdOf(copiBitsA), {TB_OP, 24'h000000});
    @(negedge clk);
    checkOutput("b2b_restart", {31'd0, busyA}, 32'd1);
    checkOutput("b2b_gap", 32'(csHighA >= CSH_A), 32'd1);
    startA = 1'b0;
    waitIdleA();
    checkOutput("b2b_data1",  dataA, 32'hA500FF03);
    checkOutput("b2b_cmd1",   cmdOf(copiBitsA), {TB_OP, 24'hFFFFFC});
    checkOutput("b2b_rises",  32'(riseA), 32'(TB_BITS));

    checkOutput("stabA", 32'(stabErrA), 32'd0);
    checkOutput("idleA", 32'(idleErrA), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
